// File: rtl/llc_pipe_pkg.sv
// Shared LLC pipeline definitions: stage packet layouts, their widths, and
// FIFO sizing helpers used by every inter-stage buffer.
package llc_pipe_pkg;

    localparam int LLC_SET_BITS   = 6;
    localparam int LLC_TAG_BITS   = 10;
    localparam int LLC_STATE_BITS = 2;
    localparam int LLC_WAYS       = 4;
    localparam int LLC_NUM_PORTS  = 2;

    localparam int LLC_WAY_BITS  = (LLC_WAYS > 1) ? $clog2(LLC_WAYS) : 1;
    localparam int LLC_PORT_BITS = (LLC_NUM_PORTS > 1) ? $clog2(LLC_NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        LLC_OP_READ  = 2'd0,
        LLC_OP_WRITE = 2'd1,
        LLC_OP_EVICT = 2'd2,
        LLC_OP_INVAL = 2'd3
    } llc_op_e;

    // Decode -> local memory
    typedef struct packed {
        logic [LLC_PORT_BITS-1:0] port;
        llc_op_e                  op;
        logic [LLC_SET_BITS-1:0]  set;
        logic [LLC_TAG_BITS-1:0]  tag;
    } llc_mem_pkt_t;

    // Local memory -> lookup
    typedef struct packed {
        llc_mem_pkt_t                            req;
        logic [LLC_WAYS-1:0][LLC_TAG_BITS-1:0]   way_tags;
        logic [LLC_WAYS-1:0][LLC_STATE_BITS-1:0] way_states;
    } llc_lookup_pkt_t;

    // Lookup -> process
    typedef struct packed {
        llc_mem_pkt_t              req;
        logic                      hit;
        logic [LLC_WAY_BITS-1:0]   way;
        logic [LLC_STATE_BITS-1:0] state;
    } llc_process_pkt_t;

    // Process -> update
    typedef struct packed {
        logic [LLC_PORT_BITS-1:0]  port;
        logic [LLC_SET_BITS-1:0]   set;
        logic [LLC_WAY_BITS-1:0]   way;
        logic [LLC_TAG_BITS-1:0]   tag;
        logic [LLC_STATE_BITS-1:0] next_state;
    } llc_update_pkt_t;

    localparam int LLC_MEM_PKT_W     = $bits(llc_mem_pkt_t);
    localparam int LLC_LOOKUP_PKT_W  = $bits(llc_lookup_pkt_t);
    localparam int LLC_PROCESS_PKT_W = $bits(llc_process_pkt_t);
    localparam int LLC_UPDATE_PKT_W  = $bits(llc_update_pkt_t);

    // Pointer width for a circular buffer of the given depth; never zero.
    function automatic int fifo_ptr_bits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/llc_pipe_fifo_if.sv
// Stage-to-stage FIFO interface: the producer/consumer side is the master,
// the FIFO itself is the slave.
interface llc_pipe_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int UW = $clog2(DEPTH + 1);

    logic             flush;
    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic [UW-1:0]    usage;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, data_in, pop, clr_err,
        input  data_out, valid_out, full, almost_full, empty, usage,
               overflow, underflow
    );

    modport slave (
        input  flush, push, data_in, pop, clr_err,
        output data_out, valid_out, full, almost_full, empty, usage,
               overflow, underflow
    );

endinterface

// File: rtl/llc_pipe_fifo_ptr.sv
// Wrap-around circular-buffer pointer: counts 0..DEPTH-1 and wraps to 0,
// which also covers depths that are not a power of two.
module llc_pipe_fifo_ptr
    import llc_pipe_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = fifo_ptr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [PW-1:0] o_value
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_value;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= (r_value == LAST) ? '0 : r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/llc_pipe_fifo.sv
// Parametrised inter-stage FIFO with optional empty fall-through, early
// back-pressure threshold and sticky overflow/underflow flags.
module llc_pipe_fifo
    import llc_pipe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit BYPASS    = 1'b0,
    parameter int AF_THRESH = (DEPTH > 1) ? DEPTH - 1 : 1
) (
    input  logic           clk,
    input  logic           rst,
    llc_pipe_fifo_if.slave fifo
);

    localparam int PW = fifo_ptr_bits(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);

    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [UW-1:0] AF_U    = UW'(AF_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [UW-1:0]    r_usage;
    logic             r_overflow;
    logic             r_underflow;

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_valid;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_do_pop;
    logic          w_do_push;
    logic          w_pass;
    logic          w_wr_inc;
    logic          w_rd_inc;
    logic          w_ovf_set;
    logic          w_udf_set;

    assign w_full  = (r_usage == DEPTH_U);
    assign w_empty = (r_usage == '0);
    assign w_valid = BYPASS ? (!w_empty || fifo.push) : !w_empty;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign w_pop_ok  = fifo.pop && w_valid;
    assign w_push_ok = fifo.push && (!w_full || w_pop_ok);
    assign w_do_pop  = w_pop_ok && !fifo.flush;
    assign w_do_push = w_push_ok && !fifo.flush;

    // Fall-through: the entry goes straight to the consumer and is never stored.
    assign w_pass   = BYPASS && w_empty && w_do_push && w_do_pop;
    assign w_wr_inc = w_do_push && !w_pass;
    assign w_rd_inc = w_do_pop && !w_pass;

    assign w_ovf_set = fifo.push && w_full && !w_pop_ok && !fifo.flush;
    assign w_udf_set = fifo.pop && !w_valid && !fifo.flush;

    llc_pipe_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_wr_inc),
        .i_clr   (fifo.flush),
        .o_value (w_wr_ptr)
    );

    llc_pipe_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_rd_inc),
        .i_clr   (fifo.flush),
        .o_value (w_rd_ptr)
    );

    // NOTE: storage has no reset; occupancy alone decides what is valid, and
    // leaving the array unreset lets it map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (w_wr_inc) begin
            r_mem[w_wr_ptr] <= fifo.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_usage <= '0;
        end else if (fifo.flush) begin
            r_usage <= '0;
        end else begin
            r_usage <= r_usage + UW'(w_wr_inc) - UW'(w_rd_inc);
        end
    end

    // Sticky flags: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow && !fifo.clr_err) || w_ovf_set;
            r_underflow <= (r_underflow && !fifo.clr_err) || w_udf_set;
        end
    end

    assign fifo.data_out    = (BYPASS && w_empty) ? fifo.data_in : r_mem[w_rd_ptr];
    assign fifo.valid_out   = w_valid;
    assign fifo.full        = w_full;
    assign fifo.almost_full = (r_usage >= AF_U);
    assign fifo.empty       = w_empty;
    assign fifo.usage       = r_usage;
    assign fifo.overflow    = r_overflow;
    assign fifo.underflow   = r_underflow;

endmodule

// File: tb/tb_llc_pipe_fifo.sv
// Directed bench for llc_pipe_fifo: a DEPTH=4 buffer, a DEPTH=3 buffer for
// pointer wrap, and a DEPTH=4 fall-through buffer share one clock and reset.
module tb_llc_pipe_fifo;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    llc_pipe_fifo_if #(.WIDTH(8), .DEPTH(4)) if_a ();
    llc_pipe_fifo_if #(.WIDTH(8), .DEPTH(3)) if_b ();
    llc_pipe_fifo_if #(.WIDTH(8), .DEPTH(4)) if_c ();

    llc_pipe_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) u_a (
        .clk (clk), .rst (rst), .fifo (if_a.slave));
    llc_pipe_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(1'b0)) u_b (
        .clk (clk), .rst (rst), .fifo (if_b.slave));
    llc_pipe_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) u_c (
        .clk (clk), .rst (rst), .fifo (if_c.slave));

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (if_a.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", if_a.empty); end
        n_vec++; if (if_a.full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", if_a.full); end
        n_vec++; if (if_a.almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af: got %b want 0", if_a.almost_full); end
        n_vec++; if (if_a.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_a.valid_out); end
        n_vec++; if (if_a.usage !== 3'd0) begin n_err++; $display("FAIL rst_usage: got %0d want 0", if_a.usage); end
        n_vec++; if (if_a.overflow !== 1'b0 || if_a.underflow !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: got ovf=%b udf=%b want 0 0", if_a.overflow, if_a.underflow); end
        n_vec++; if (if_b.empty !== 1'b1 || if_c.empty !== 1'b1) begin
            n_err++; $display("FAIL rst_empty_bc: got b=%b c=%b want 1 1", if_b.empty, if_c.empty); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            if_a.push = 1'b1; if_a.data_in = vals[i];
            step();
            n_vec++; if (if_a.usage !== 3'(i + 1)) begin n_err++; $display("FAIL fill_usage%0d: got %0d want %0d", i, if_a.usage, i + 1); end
            n_vec++; if (if_a.almost_full !== (i >= 2)) begin n_err++; $display("FAIL fill_af%0d: got %b want %b", i, if_a.almost_full, i >= 2); end
            n_vec++; if (if_a.full !== (i == 3)) begin n_err++; $display("FAIL fill_full%0d: got %b want %b", i, if_a.full, i == 3); end
        end
        if_a.data_in = 8'h55;
        step();
        if_a.push = 1'b0;
        n_vec++; if (if_a.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", if_a.overflow); end
        n_vec++; if (if_a.usage !== 3'd4) begin n_err++; $display("FAIL ovf_usage: got %0d want 4", if_a.usage); end
        n_vec++; if (if_a.data_out !== 8'h11) begin n_err++; $display("FAIL ovf_head: got %h want 11", if_a.data_out); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] drain [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        n_vec++; if (if_a.data_out !== 8'h11 || if_a.valid_out !== 1'b1) begin
            n_err++; $display("FAIL pp_head: got %h/%b want 11/1", if_a.data_out, if_a.valid_out); end
        if_a.push = 1'b1; if_a.pop = 1'b1; if_a.data_in = 8'h66;
        step();
        if_a.push = 1'b0; if_a.pop = 1'b0;
        n_vec++; if (if_a.usage !== 3'd4) begin n_err++; $display("FAIL pp_usage: got %0d want 4", if_a.usage); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (if_a.data_out !== drain[i] || if_a.valid_out !== 1'b1) begin
                n_err++; $display("FAIL drain%0d: got %h/%b want %h/1", i, if_a.data_out, if_a.valid_out, drain[i]); end
            if_a.pop = 1'b1;
            step();
            if_a.pop = 1'b0;
        end
        n_vec++; if (if_a.empty !== 1'b1 || if_a.usage !== 3'd0) begin
            n_err++; $display("FAIL drain_empty: got %b/%0d want 1/0", if_a.empty, if_a.usage); end
        if_a.clr_err = 1'b1;
        step();
        if_a.clr_err = 1'b0;
        n_vec++; if (if_a.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", if_a.overflow); end
    endtask

    task automatic test_wrap();
        if_b.push = 1'b1; if_b.data_in = 8'h00;
        step();
        for (int i = 1; i < 10; i++) begin
            n_vec++; if (if_b.data_out !== 8'(i - 1) || if_b.usage !== 2'd1) begin
                n_err++; $display("FAIL wrap%0d: got %h/%0d want %h/1", i, if_b.data_out, if_b.usage, 8'(i - 1)); end
            if_b.push = 1'b1; if_b.pop = 1'b1; if_b.data_in = 8'(i);
            step();
        end
        if_b.push = 1'b0;
        n_vec++; if (if_b.data_out !== 8'h09) begin n_err++; $display("FAIL wrap_last: got %h want 09", if_b.data_out); end
        step();
        if_b.pop = 1'b0;
        n_vec++; if (if_b.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", if_b.empty); end
        n_vec++; if (if_b.overflow !== 1'b0 || if_b.underflow !== 1'b0) begin
            n_err++; $display("FAIL wrap_flags: got ovf=%b udf=%b want 0 0", if_b.overflow, if_b.underflow); end
    endtask

    task automatic test_bypass();
        if_c.push = 1'b1; if_c.pop = 1'b1; if_c.data_in = 8'hA5;
        #1;
        n_vec++; if (if_c.data_out !== 8'hA5 || if_c.valid_out !== 1'b1) begin
            n_err++; $display("FAIL byp_pass: got %h/%b want a5/1", if_c.data_out, if_c.valid_out); end
        step();
        if_c.pop = 1'b0; if_c.data_in = 8'h5A;
        n_vec++; if (if_c.usage !== 3'd0) begin n_err++; $display("FAIL byp_usage0: got %0d want 0", if_c.usage); end
        #1;
        n_vec++; if (if_c.data_out !== 8'h5A || if_c.valid_out !== 1'b1) begin
            n_err++; $display("FAIL byp_comb: got %h/%b want 5a/1", if_c.data_out, if_c.valid_out); end
        step();
        if_c.push = 1'b0;
        n_vec++; if (if_c.usage !== 3'd1 || if_c.data_out !== 8'h5A) begin
            n_err++; $display("FAIL byp_stored: got %0d/%h want 1/5a", if_c.usage, if_c.data_out); end
        if_c.pop = 1'b1;
        step();
        if_c.pop = 1'b0;
        n_vec++; if (if_c.empty !== 1'b1 || if_c.underflow !== 1'b0) begin
            n_err++; $display("FAIL byp_drain: got empty=%b udf=%b want 1 0", if_c.empty, if_c.underflow); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            if_a.push = 1'b1; if_a.data_in = 8'(i);
            step();
        end
        n_vec++; if (if_a.usage !== 3'd3) begin n_err++; $display("FAIL fl_pre: got %0d want 3", if_a.usage); end
        if_a.flush = 1'b1; if_a.data_in = 8'h77;
        step();
        if_a.flush = 1'b0; if_a.push = 1'b0;
        n_vec++; if (if_a.usage !== 3'd0 || if_a.empty !== 1'b1 || if_a.valid_out !== 1'b0) begin
            n_err++; $display("FAIL fl_clear: got %0d/%b/%b want 0/1/0", if_a.usage, if_a.empty, if_a.valid_out); end
        if_a.push = 1'b1; if_a.data_in = 8'h99;
        step();
        if_a.push = 1'b0;
        n_vec++; if (if_a.data_out !== 8'h99 || if_a.usage !== 3'd1) begin
            n_err++; $display("FAIL fl_next: got %h/%0d want 99/1", if_a.data_out, if_a.usage); end
        if_a.pop = 1'b1;
        step();
        step();
        if_a.pop = 1'b0;
        n_vec++; if (if_a.underflow !== 1'b1) begin n_err++; $display("FAIL udf_set: got %b want 1", if_a.underflow); end
        if_a.clr_err = 1'b1; if_a.pop = 1'b1;
        step();
        if_a.pop = 1'b0;
        n_vec++; if (if_a.underflow !== 1'b1) begin n_err++; $display("FAIL udf_setwins: got %b want 1", if_a.underflow); end
        step();
        if_a.clr_err = 1'b0;
        n_vec++; if (if_a.underflow !== 1'b0) begin n_err++; $display("FAIL udf_clr: got %b want 0", if_a.underflow); end
    endtask

    task automatic test_async_reset();
        if_a.pop = 1'b1;
        step();
        if_a.pop = 1'b0; if_a.push = 1'b1; if_a.data_in = 8'h10;
        step();
        if_a.data_in = 8'h20;
        step();
        if_a.push = 1'b0;
        n_vec++; if (if_a.usage !== 3'd2 || if_a.underflow !== 1'b1) begin
            n_err++; $display("FAIL ar_pre: got %0d/%b want 2/1", if_a.usage, if_a.underflow); end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (if_a.empty !== 1'b1 || if_a.usage !== 3'd0) begin
            n_err++; $display("FAIL ar_state: got %b/%0d want 1/0", if_a.empty, if_a.usage); end
        n_vec++; if (if_a.overflow !== 1'b0 || if_a.underflow !== 1'b0) begin
            n_err++; $display("FAIL ar_flags: got ovf=%b udf=%b want 0 0", if_a.overflow, if_a.underflow); end
        #3;
        rst = 1'b1;
        step();
        if_a.push = 1'b1; if_a.data_in = 8'h3C;
        step();
        if_a.push = 1'b0;
        n_vec++; if (if_a.data_out !== 8'h3C || if_a.valid_out !== 1'b1 || if_a.usage !== 3'd1) begin
            n_err++; $display("FAIL ar_push: got %h/%b/%0d want 3c/1/1", if_a.data_out, if_a.valid_out, if_a.usage); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b0;
        {if_a.flush, if_a.push, if_a.pop, if_a.clr_err, if_a.data_in} = '0;
        {if_b.flush, if_b.push, if_b.pop, if_b.clr_err, if_b.data_in} = '0;
        {if_c.flush, if_c.push, if_c.pop, if_c.clr_err, if_c.data_in} = '0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_bypass();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
